// File: rtl/ones_count_det_pkg.sv
// Shared definitions for the ones-count detector: FSM states and mode codes.
package ones_count_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_CUM    = 1'b0;
  localparam logic MODE_CONSEC = 1'b1;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with asynchronous active-low reset and synchronous clear.
module sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Count up on inc, hold at all-ones once reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  q <= '0;
    else if (clr)              q <= '0;
    else if (inc && (q != '1)) q <= q + 1'b1;
  end

endmodule

// File: rtl/ones_count_det.sv
// Serial ones-count detector: counts sampled ones, pulses flag for one cycle
// when the count reaches target, and tallies detections in a saturating counter.
module ones_count_det
  import ones_count_det_pkg::*;
#(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned HIT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             mode,
  input  logic [CNT_W-1:0] target,
  input  logic             data,
  output logic             flag,
  output logic [CNT_W-1:0] count,
  output logic [HIT_W-1:0] hits,
  output logic             busy
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] count_nx;
  logic [CNT_W:0]   inc_wide;
  logic             one;
  logic             enter_done;

  assign one      = en & data;
  // One extra bit so the >= compare against target never wraps.
  assign inc_wide = {1'b0, count} + 1'b1;

  // Next-state and next-count decode; clr overrides everything.
  always_comb begin
    state_nx = state;
    count_nx = count;
    if (clr) begin
      state_nx = IDLE;
      count_nx = '0;
    end else begin
      case (state)
        IDLE, COUNT: begin
          if (one) begin
            if ((target != '0) && (inc_wide >= {1'b0, target})) begin
              state_nx = DONE;
              count_nx = target;
            end else begin
              state_nx = COUNT;
              count_nx = inc_wide[CNT_W] ? '1 : inc_wide[CNT_W-1:0];
            end
          end else if (en && (mode == MODE_CONSEC)) begin
            state_nx = IDLE;
            count_nx = '0;
          end
        end
        DONE: begin
          // The exit edge treats its own input as the first bit of a new run.
          if (one && (target == CNT_W'(1))) begin
            state_nx = DONE;
            count_nx = CNT_W'(1);
          end else if (one && (target > CNT_W'(1))) begin
            state_nx = COUNT;
            count_nx = CNT_W'(1);
          end else begin
            state_nx = IDLE;
            count_nx = '0;
          end
        end
        default: begin
          state_nx = IDLE;
          count_nx = '0;
        end
      endcase
    end
  end

  assign enter_done = (state_nx == DONE);

  // State, count and a dedicated flag flop so flag never decodes combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      flag  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      flag  <= enter_done;
    end
  end

  assign busy = (state == COUNT);

  sat_cnt #(.W(HIT_W)) u_hits (
    .clk (clk),
    .rst (rst),
    .inc (enter_done),
    .clr (1'b0),
    .q   (hits)
  );

endmodule
